// File: rtl/ex_fwd_stage.sv
// Execute-stage control: MEM/WB operand forwarding, load-use stall detection, EX/MEM register.
// Latency: op1E/op2E/stall are combinational; all *M outputs are registered with 1-cycle latency.
// Backpressure: none. stall requests a bubble from the D/E register, and the EX/MEM register always captures.
//
// Ports:
//   CLK, RST_N           clock (posedge), async active-low reset
//   pcE..reg_writeE      instruction fields from the decode/execute register
//   reg_data1E/2E, immE  register-file read data and immediate
//   rs1D, rs2D           decode-stage sources, used for load-use detection
//   alu_resultE          ALU result of the EX instruction
//   rdW/reg_writeW/wb_dataW  writeback stage destination and data
//   op1E, op2E           forwarded ALU operands (comb)
//   stall                load-use bubble request (comb)
//   pcM..reg_writeM      EX/MEM pipeline register outputs
// Optional feature macro: EX_PERF_CNT_EN adds the stall_cnt and fwd_cnt counter outputs.
module ex_fwd_stage #(
  parameter int PC_W  = 13,
  parameter int XLEN  = 32
`ifdef EX_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [PC_W-1:0] pcE,
  input  logic [31:0]     instE,
  input  logic            alu_srcE,
  input  logic [XLEN-1:0] reg_data1E,
  input  logic [XLEN-1:0] reg_data2E,
  input  logic [XLEN-1:0] immE,
  input  logic [4:0]      rs1E,
  input  logic [4:0]      rs2E,
  input  logic [4:0]      rdE,
  input  logic [1:0]      mem_storeE,
  input  logic [2:0]      mem_loadE,
  input  logic            reg_writeE,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [XLEN-1:0] alu_resultE,
  input  logic [4:0]      rdW,
  input  logic            reg_writeW,
  input  logic [XLEN-1:0] wb_dataW,
  output logic [XLEN-1:0] op1E,
  output logic [XLEN-1:0] op2E,
  output logic            stall,
  output logic [PC_W-1:0] pcM,
  output logic [31:0]     instM,
  output logic [XLEN-1:0] resultM,
  output logic [XLEN-1:0] store_dataM,
  output logic [4:0]      rdM,
  output logic [1:0]      mem_storeM,
  output logic [2:0]      mem_loadM,
  output logic            reg_writeM
`ifdef EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
`endif
);

  logic            m_src_ok;
  logic            w_src_ok;
  logic            fwd_m1, fwd_w1, fwd_m2, fwd_w2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A load in M has no data yet, so it is never a forwarding source.
  // The load-use stall guarantees the consumer picks the value up from W instead.
  // Requiring rd != 0 also keeps x0 reads on the regfile path.
  assign m_src_ok = reg_writeM && (rdM != 5'd0) && (mem_loadM == 3'd0);
  assign w_src_ok = reg_writeW && (rdW != 5'd0);

  assign fwd_m1 = m_src_ok && (rdM == rs1E);
  assign fwd_w1 = w_src_ok && (rdW == rs1E);
  assign fwd_m2 = m_src_ok && (rdM == rs2E);
  assign fwd_w2 = w_src_ok && (rdW == rs2E);

  // M has priority over W because it holds the younger write.
  assign fwd_rs1 = fwd_m1 ? resultM : (fwd_w1 ? wb_dataW : reg_data1E);
  assign fwd_rs2 = fwd_m2 ? resultM : (fwd_w2 ? wb_dataW : reg_data2E);

  assign op1E = fwd_rs1;
  assign op2E = alu_srcE ? immE : fwd_rs2;

  // The bubble that follows carries reg_writeE=0, so one load stalls for at most one cycle.
  assign stall = (mem_loadE != 3'd0) && reg_writeE && (rdE != 5'd0) &&
                 ((rdE == rs1D) || (rdE == rs2D));

  // EX/MEM register. There is no enable: bubbles flow through as
  // reg_writeM / mem_storeM / mem_loadM = 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcM         <= '0;
      instM       <= '0;
      resultM     <= '0;
      store_dataM <= '0;
      rdM         <= '0;
      mem_storeM  <= '0;
      mem_loadM   <= '0;
      reg_writeM  <= 1'b0;
    end else begin
      pcM         <= pcE;
      instM       <= instE;
      resultM     <= alu_resultE;
      store_dataM <= fwd_rs2;
      rdM         <= rdE;
      mem_storeM  <= mem_storeE;
      mem_loadM   <= mem_loadE;
      reg_writeM  <= reg_writeE;
    end
  end

`ifdef EX_PERF_CNT_EN
  logic fwd_used;

  // op2 only counts when it actually takes the register path (not the immediate).
  // At most one increment per cycle, even when both operands are forwarded.
  assign fwd_used = fwd_m1 || fwd_w1 || (!alu_srcE && (fwd_m2 || fwd_w2));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall)    stall_cnt <= stall_cnt + 1'b1;
      if (fwd_used) fwd_cnt   <= fwd_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_fwd_stage.sv
module tb_ex_fwd_stage;

  logic        CLK;
  logic        RST_N;
  logic [12:0] pcE;
  logic [31:0] instE;
  logic        alu_srcE;
  logic [31:0] reg_data1E, reg_data2E, immE;
  logic [4:0]  rs1E, rs2E, rdE;
  logic [1:0]  mem_storeE;
  logic [2:0]  mem_loadE;
  logic        reg_writeE;
  logic [4:0]  rs1D, rs2D;
  logic [31:0] alu_resultE;
  logic [4:0]  rdW;
  logic        reg_writeW;
  logic [31:0] wb_dataW;
  logic [31:0] op1E, op2E;
  logic        stall;
  logic [12:0] pcM;
  logic [31:0] instM, resultM, store_dataM;
  logic [4:0]  rdM;
  logic [1:0]  mem_storeM;
  logic [2:0]  mem_loadM;
  logic        reg_writeM;
`ifdef EX_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int errors = 0;
  int checks = 0;

  ex_fwd_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .pcE(pcE), .instE(instE), .alu_srcE(alu_srcE),
    .reg_data1E(reg_data1E), .reg_data2E(reg_data2E), .immE(immE),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .mem_storeE(mem_storeE), .mem_loadE(mem_loadE), .reg_writeE(reg_writeE),
    .rs1D(rs1D), .rs2D(rs2D), .alu_resultE(alu_resultE),
    .rdW(rdW), .reg_writeW(reg_writeW), .wb_dataW(wb_dataW),
    .op1E(op1E), .op2E(op2E), .stall(stall),
    .pcM(pcM), .instM(instM), .resultM(resultM), .store_dataM(store_dataM),
    .rdM(rdM), .mem_storeM(mem_storeM), .mem_loadM(mem_loadM), .reg_writeM(reg_writeM)
`ifdef EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    pcE = '0; instE = '0; alu_srcE = 1'b0;
    reg_data1E = '0; reg_data2E = '0; immE = '0;
    rs1E = '0; rs2E = '0; rdE = '0;
    mem_storeE = '0; mem_loadE = '0; reg_writeE = 1'b0;
    rs1D = '0; rs2D = '0; alu_resultE = '0;
    rdW = '0; reg_writeW = 1'b0; wb_dataW = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST_N = 1'b0;
    #3;
    checks++;
    if ({pcM, instM, resultM, store_dataM, rdM, mem_storeM, mem_loadM, reg_writeM} !== '0) begin
      errors++;
      $display("FAIL reset_initial: M outputs nonzero pcM=%h instM=%h resultM=%h", pcM, instM, resultM);
    end
    tick();
    RST_N = 1'b1;
    // Load E with a recognisable store instruction and capture it.
    pcE = 13'h1ABC; instE = 32'hCAFE_0123; alu_resultE = 32'h1234_5678;
    rdE = 5'd9; mem_storeE = 2'd2; mem_loadE = 3'd0; reg_writeE = 1'b1;
    rs2E = 5'd4; reg_data2E = 32'h0000_BEEF;
    tick();
    checks++;
    if (pcM !== 13'h1ABC || instM !== 32'hCAFE_0123) begin
      errors++;
      $display("FAIL capture_pc_inst: pcM=%h instM=%h required 1abc cafe0123", pcM, instM);
    end
    checks++;
    if (resultM !== 32'h1234_5678 || store_dataM !== 32'h0000_BEEF || rdM !== 5'd9) begin
      errors++;
      $display("FAIL capture_data: resultM=%h store_dataM=%h rdM=%0d required 12345678 0000beef 9",
               resultM, store_dataM, rdM);
    end
    checks++;
    if (mem_storeM !== 2'd2 || reg_writeM !== 1'b1) begin
      errors++;
      $display("FAIL capture_ctrl: mem_storeM=%0d reg_writeM=%b required 2 1", mem_storeM, reg_writeM);
    end
    // Mid-cycle asynchronous reset clears M immediately.
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({pcM, instM, resultM, store_dataM, rdM, mem_storeM, mem_loadM, reg_writeM} !== '0) begin
      errors++;
      $display("FAIL reset_async: M outputs nonzero pcM=%h resultM=%h reg_writeM=%b", pcM, resultM, reg_writeM);
    end
    // With M cleared, operands come straight from the regfile.
    rs1E = 5'd9; reg_data1E = 32'h0000_0042;
    #1;
    checks++;
    if (op1E !== 32'h0000_0042) begin
      errors++;
      $display("FAIL reset_regfile: op1E=%h required 00000042", op1E);
    end
    #2;
    RST_N = 1'b1;
    tick();
    checks++;
    if (pcM !== 13'h1ABC || reg_writeM !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: pcM=%h reg_writeM=%b required 1abc 1", pcM, reg_writeM);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_ex_ex_fwd();
    clear_inputs();
    // addi x5 -> result 0x10 moves into M.
    reg_writeE = 1'b1; rdE = 5'd5; alu_resultE = 32'h10;
    tick();
    clear_inputs();
    rs1E = 5'd5; reg_data1E = 32'h0000_0123;
    #1;
    checks++;
    if (op1E !== 32'h10) begin
      errors++;
      $display("FAIL ex_ex_fwd: op1E=%h required 00000010", op1E);
    end
    // No match on rs2: op2E stays on the regfile path.
    rs2E = 5'd6; reg_data2E = 32'h0000_0066;
    #1;
    checks++;
    if (op2E !== 32'h66) begin
      errors++;
      $display("FAIL no_match: op2E=%h required 00000066", op2E);
    end
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    reg_writeE = 1'b1; rdE = 5'd7; alu_resultE = 32'hA;
    tick();
    clear_inputs();
    rdW = 5'd7; reg_writeW = 1'b1; wb_dataW = 32'hB;
    rs2E = 5'd7; reg_data2E = 32'hC; alu_srcE = 1'b0; immE = 32'h55;
    #1;
    checks++;
    if (op2E !== 32'hA) begin
      errors++;
      $display("FAIL fwd_priority: op2E=%h required 0000000a", op2E);
    end
    tick();
    checks++;
    if (store_dataM !== 32'hA) begin
      errors++;
      $display("FAIL store_data_fwd: store_dataM=%h required 0000000a", store_dataM);
    end
    // M now holds a bubble, so W is the only source.
    checks++;
    if (op2E !== 32'hB) begin
      errors++;
      $display("FAIL fwd_w_only: op2E=%h required 0000000b", op2E);
    end
    alu_srcE = 1'b1;
    #1;
    checks++;
    if (op2E !== 32'h55) begin
      errors++;
      $display("FAIL alu_src_imm: op2E=%h required 00000055", op2E);
    end
    // store_dataM still takes the forwarded rs2 even though op2E uses the immediate.
    tick();
    checks++;
    if (store_dataM !== 32'hB) begin
      errors++;
      $display("FAIL store_data_imm: store_dataM=%h required 0000000b", store_dataM);
    end
    reg_writeW = 1'b0;
    alu_srcE = 1'b0;
    #1;
    checks++;
    if (op2E !== 32'hC) begin
      errors++;
      $display("FAIL fwd_none: op2E=%h required 0000000c", op2E);
    end
    tick();
  endtask

  task automatic test_x0();
    clear_inputs();
    reg_writeE = 1'b1; rdE = 5'd0; alu_resultE = 32'hFFFF;
    tick();
    clear_inputs();
    rs1E = 5'd0; reg_data1E = 32'h0;
    reg_writeW = 1'b1; rdW = 5'd0; wb_dataW = 32'hFFFF;
    #1;
    checks++;
    if (op1E !== 32'h0) begin
      errors++;
      $display("FAIL x0_guard: op1E=%h required 00000000", op1E);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    // lw x3 in E, decode instruction reads x3 on rs2.
    mem_loadE = 3'd2; reg_writeE = 1'b1; rdE = 5'd3; rs2D = 5'd3; rs1D = 5'd8;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b required 1", stall);
    end
    // Matching rdE of 0 must not stall.
    rdE = 5'd0; rs2D = 5'd0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL load_x0_nostall: stall=%b required 0", stall);
    end
    rdE = 5'd3; rs2D = 5'd3;
    tick();
    // Bubble in E; the load sits in M.
    mem_loadE = 3'd0; reg_writeE = 1'b0; rdE = 5'd0;
    rs2E = 5'd3; reg_data2E = 32'h77;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL bubble_nostall: stall=%b required 0", stall);
    end
    checks++;
    if (mem_loadM !== 3'd2 || op2E !== 32'h77) begin
      errors++;
      $display("FAIL load_in_m_nofwd: mem_loadM=%0d op2E=%h required 2 00000077", mem_loadM, op2E);
    end
    tick();
    // Consumer in E, loaded data arrives from W.
    rs2D = 5'd0;
    rdW = 5'd3; reg_writeW = 1'b1; wb_dataW = 32'hDEAD;
    #1;
    checks++;
    if (op2E !== 32'hDEAD || mem_loadM !== 3'd0 || reg_writeM !== 1'b0) begin
      errors++;
      $display("FAIL load_w_fwd: op2E=%h mem_loadM=%0d reg_writeM=%b required 0000dead 0 0",
               op2E, mem_loadM, reg_writeM);
    end
    tick();
  endtask

`ifdef EX_PERF_CNT_EN
  task automatic test_perf_cnt();
    clear_inputs();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_loadE = 3'd2; reg_writeE = 1'b1; rdE = 5'd3; rs1D = 5'd3;
      tick();
      clear_inputs();
      tick();
    end
    reg_writeW = 1'b1; rdW = 5'd9; wb_dataW = 32'h99; rs1E = 5'd9;
    for (int i = 0; i < 4; i++) tick();
    clear_inputs();
    tick();
    checks++;
    if (stall_cnt !== 32'd3 || fwd_cnt !== 32'd4) begin
      errors++;
      $display("FAIL perf_cnt: stall_cnt=%0d fwd_cnt=%0d required 3 4", stall_cnt, fwd_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ex_ex_fwd();
    test_priority();
    test_x0();
    test_load_use();
`ifdef EX_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
